// File: rtl/fetch_stage.sv
// fetch_stage
//   Producer side of the IF/ID pipe. Owns the PC, issues instruction-memory
//   reads, and presents the fetched instruction and its next-PC to IF/ID along
//   with IF/ID's enable and flush. A one-entry hold buffer absorbs hazard-unit
//   stalls. Branch/jump redirects that arrive while a read is still in flight
//   are parked until that read returns.
//
// Ports
//   CLK          in   1   clock, rising edge
//   RST          in   1   asynchronous reset, active-high
//   imemREN      out  1   instruction read request, held until ihit
//   imemaddr     out  32  read address, stable while a request is open
//   ihit         in   1   read completes this cycle, imemload valid
//   imemload     in   32  instruction word
//   stall        in   1   IF/ID must not load this cycle
//   redirect     in   1   taken branch/jump, restart fetch at redirect_pc
//   redirect_pc  in   32  redirect target (bits [1:0] forced to zero)
//   halt         in   1   stop fetching until reset
//   ifid_instr   out  32  IF/ID instruction input
//   ifid_npc     out  32  IF/ID next-PC input (instruction address + 4)
//   ifid_en      out  1   IF/ID load enable
//   ifid_flush   out  1   IF/ID flush
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_en,
    output logic        ifid_flush
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] buf_reg, buf_next;
    logic [31:0] tgt_reg, tgt_next;
    logic        halt_reg, halt_next;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_word;
    logic        active;
    logic        halting;

    assign pc_plus4      = pc_reg + 32'd4;
    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

    // BOOT and HALTED ignore redirect and halt entirely.
    assign active  = (state_reg == FETCH) || (state_reg == HOLD) || (state_reg == DRAIN);
    // A halt seen once stays in force until reset.
    assign halting = halt || halt_reg;

    // Output decode. The IF/ID side is combinational so a hit is captured on
    // the same edge the memory returns it.
    always_comb begin
        imemREN    = 1'b0;
        imemaddr   = pc_reg;
        ifid_instr = 32'd0;
        ifid_npc   = pc_plus4;
        ifid_en    = 1'b0;
        ifid_flush = active && redirect;
        case (state_reg)
            FETCH: begin
                imemREN    = 1'b1;
                ifid_instr = imemload;
                ifid_en    = ihit && !stall && !redirect && !halting;
            end
            HOLD: begin
                ifid_instr = buf_reg;
                ifid_en    = !stall && !redirect && !halting;
            end
            DRAIN: begin
                // The old read cannot be cancelled; keep it open until it lands.
                imemREN = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next-state logic. Halt outranks redirect, which outranks normal flow.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        buf_next   = buf_reg;
        tgt_next   = tgt_reg;
        halt_next  = halt_reg || (halt && active);
        case (state_reg)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (halting) begin
                    if (ihit) begin
                        state_next = HALTED;
                    end
                end else if (redirect) begin
                    if (ihit) begin
                        pc_next = redirect_word;
                    end else begin
                        tgt_next   = redirect_word;
                        state_next = DRAIN;
                    end
                end else if (ihit) begin
                    if (stall) begin
                        buf_next   = imemload;
                        state_next = HOLD;
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (halting) begin
                    state_next = HALTED;
                end else if (redirect) begin
                    pc_next    = redirect_word;
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (halting) begin
                    if (ihit) begin
                        state_next = HALTED;
                    end
                end else if (redirect) begin
                    // Latest redirect wins over any parked target.
                    tgt_next = redirect_word;
                    if (ihit) begin
                        pc_next    = redirect_word;
                        state_next = FETCH;
                    end
                end else if (ihit) begin
                    pc_next    = tgt_reg;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= BOOT;
            pc_reg    <= PC_INIT;
            buf_reg   <= 32'd0;
            tgt_reg   <= 32'd0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            buf_reg   <= buf_next;
            tgt_reg   <= tgt_next;
            halt_reg  <= halt_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed scenarios with literal expectations, then randomized stimulus
//   compared every cycle against an event-level model of the fetch stage.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_en;
    logic        ifid_flush;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK),
        .RST(RST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .ifid_instr(ifid_instr),
        .ifid_npc(ifid_npc),
        .ifid_en(ifid_en),
        .ifid_flush(ifid_flush)
    );

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level model: what the fetch unit is doing right now.
    bit          m_boot, m_halted, m_held, m_drain, m_hreq;
    logic [31:0] m_pc, m_hword, m_tgt;

    task automatic model_reset();
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_held   = 1'b0;
        m_drain  = 1'b0;
        m_hreq   = 1'b0;
        m_pc     = 32'd0;
        m_hword  = 32'd0;
        m_tgt    = 32'd0;
    endtask

    // Apply one clock edge's worth of the fetch rules to the model.
    task automatic model_step();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halted) begin
            if (halt || m_hreq) begin
                m_hreq = 1'b1;
                if (m_held || ihit) m_halted = 1'b1;
            end else if (redirect) begin
                if (m_held || ihit) begin
                    m_pc    = redirect_pc & ~32'd3;
                    m_held  = 1'b0;
                    m_drain = 1'b0;
                end else begin
                    m_drain = 1'b1;
                    m_tgt   = redirect_pc & ~32'd3;
                end
            end else if (m_held) begin
                if (!stall) begin
                    m_pc   = m_pc + 32'd4;
                    m_held = 1'b0;
                end
            end else if (ihit) begin
                if (m_drain) begin
                    m_pc    = m_tgt;
                    m_drain = 1'b0;
                end else if (stall) begin
                    m_held  = 1'b1;
                    m_hword = mem_word(m_pc);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        bit active, exp_ren, exp_flush, exp_en;
        logic [31:0] exp_instr;
        active    = !m_boot && !m_halted;
        exp_ren   = active && !m_held;
        exp_flush = active && redirect;
        exp_en    = active && !redirect && !halt && !m_hreq && !stall &&
                    (m_held || (!m_drain && ihit));
        check("ren", imemREN, exp_ren);
        if (exp_ren || m_boot) check("addr", imemaddr, m_pc);
        check("flush", ifid_flush, exp_flush);
        check("en", ifid_en, exp_en);
        if (exp_en) begin
            exp_instr = m_held ? m_hword : mem_word(m_pc);
            check("instr", ifid_instr, exp_instr);
            check("npc", ifid_npc, m_pc + 32'd4);
            $display("ifid load: instr=%h npc=%h", ifid_instr, ifid_npc);
        end
    endtask

    // One cycle: the edge commits the previous inputs, then new inputs are
    // applied mid-cycle and the settled outputs compared.
    task automatic drive(input bit h, input bit s, input bit r,
                         input logic [31:0] rp, input bit hl);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        ihit        = h;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        halt        = hl;
        imemload    = h ? mem_word(imemaddr) : $urandom;
        #1;
        compare_outputs();
    endtask

    // Reset lands mid-cycle so the asynchronous drop of imemREN is visible.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("rst_ren_async", imemREN, 1'b0);
        model_reset();
        ihit     = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        compare_outputs();
    endtask

    initial begin
        int halted_cycles;
        logic [31:0] rp;

        model_reset();
        do_reset();
        check("boot_ren", imemREN, 1'b0);
        check("boot_addr", imemaddr, 32'h0);
        check("boot_en", ifid_en, 1'b0);
        check("boot_flush", ifid_flush, 1'b0);
        check("boot_instr", ifid_instr, 32'h0);
        check("boot_npc", ifid_npc, 32'h4);

        // Streaming hits: one instruction per cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 0);
            check("t1_addr", imemaddr, 32'(k * 4));
            check("t1_en", ifid_en, 1'b1);
            check("t1_npc", ifid_npc, 32'(k * 4 + 4));
        end

        // Stall on a hit at 0x10 parks the word in the hold buffer.
        drive(1, 1, 0, 0, 0);
        check("t2_addr", imemaddr, 32'h10);
        check("t2_en_stalled", ifid_en, 1'b0);
        repeat (2) begin
            drive(0, 1, 0, 0, 0);
            check("t2_hold_ren", imemREN, 1'b0);
            check("t2_hold_en", ifid_en, 1'b0);
        end
        drive(0, 0, 0, 0, 0);
        check("t2_release_en", ifid_en, 1'b1);
        check("t2_release_instr", ifid_instr, 32'hA5A5_0010);
        check("t2_release_npc", ifid_npc, 32'h14);
        drive(0, 0, 0, 0, 0);
        check("t2_next_addr", imemaddr, 32'h14);

        // Redirect while 0x20 is in flight.
        repeat (3) drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t3_addr", imemaddr, 32'h20);
        drive(0, 0, 1, 32'h100, 0);
        check("t3_flush", ifid_flush, 1'b1);
        check("t3_en", ifid_en, 1'b0);
        drive(0, 0, 0, 0, 0);
        check("t3_drain_addr", imemaddr, 32'h20);
        check("t3_drain_flush", ifid_flush, 1'b0);

        // Second redirect during the drain wins.
        drive(0, 0, 1, 32'h200, 0);
        check("t4_flush", ifid_flush, 1'b1);
        drive(1, 0, 0, 0, 0);
        check("t4_discard_en", ifid_en, 1'b0);
        check("t4_discard_addr", imemaddr, 32'h20);
        drive(0, 0, 0, 0, 0);
        check("t4_resume_addr", imemaddr, 32'h200);

        // Unaligned redirect target and PC wrap.
        drive(1, 0, 1, 32'h103, 0);
        check("t6_flush", ifid_flush, 1'b1);
        check("t6_en", ifid_en, 1'b0);
        drive(1, 0, 1, 32'hFFFF_FFFC, 0);
        check("t6_aligned_addr", imemaddr, 32'h100);
        drive(1, 0, 0, 0, 0);
        check("t6_wrap_addr", imemaddr, 32'hFFFF_FFFC);
        check("t6_wrap_en", ifid_en, 1'b1);
        check("t6_wrap_npc", ifid_npc, 32'h0);
        drive(0, 0, 0, 0, 0);
        check("t6_wrap_next", imemaddr, 32'h0);

        // Halt while a read is pending.
        drive(0, 0, 0, 0, 1);
        check("t5_ren_pending", imemREN, 1'b1);
        drive(0, 0, 0, 0, 0);
        check("t5_ren_latched", imemREN, 1'b1);
        drive(1, 0, 0, 0, 0);
        check("t5_discard_en", ifid_en, 1'b0);
        drive(1, 0, 1, 32'h40, 0);
        check("t5_halted_ren", imemREN, 1'b0);
        check("t5_halted_flush", ifid_flush, 1'b0);
        drive(1, 0, 0, 0, 0);
        check("t5_halted_ren2", imemREN, 1'b0);
        do_reset();
        check("t5_boot_ren", imemREN, 1'b0);
        check("t5_boot_addr", imemaddr, 32'h0);
        drive(1, 0, 0, 0, 0);
        check("t5_restart_en", ifid_en, 1'b1);

        // Randomized traffic against the model.
        halted_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((m_halted && halted_cycles > 4) || $urandom_range(0, 199) == 0) begin
                do_reset();
                halted_cycles = 0;
            end
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 11) == 0, rp, $urandom_range(0, 99) == 0);
            if (m_halted) halted_cycles++;
            else halted_cycles = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
